// File: rtl/sha_wb_pkg.sv
// Shared types, constants and helpers for the digest memory writer.
package sha_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SHA256_WORDS = 8;
    localparam int SHA512_WORDS = 16;

    // Widest word byte_swap can handle; callers zero-extend and truncate.
    localparam int SWAP_MAX_W = 128;

    function automatic logic [SWAP_MAX_W-1:0] byte_swap(
        input logic [SWAP_MAX_W-1:0] word,
        input int unsigned           nbytes
    );
        logic [SWAP_MAX_W-1:0] r;
        r = '0;
        for (int k = 0; k < SWAP_MAX_W / 8; k++) begin
            if (k < nbytes) begin
                r[k*8 +: 8] = word[(nbytes - 1 - k)*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/digest_word_sel.sv
// Selects one word of the captured digest (word 0 = most significant) and
// optionally reverses its byte order.
module digest_word_sel
    import sha_wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic [DATA_W*MAX_WORDS-1:0] digest,
    input  logic [CNT_W-1:0]            idx,
    input  logic                        swap,
    output logic [DATA_W-1:0]           word
);

    logic [DATA_W-1:0] raw;

    always_comb begin
        raw = '0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (idx == CNT_W'(i)) begin
                raw = digest[(MAX_WORDS-1-i)*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        word = raw;
        if (swap) begin
            word = DATA_W'(byte_swap(SWAP_MAX_W'(raw), DATA_W / 8));
        end
    end

endmodule

// File: rtl/digest_mem_writer.sv
// Captures a digest on start and streams it word by word into data memory,
// honouring back-pressure, then pulses done (and err for an invalid count).
//
// state | meaning
// IDLE  | waiting for start; memory outputs held at 0
// WRITE | presenting word idx until the memory accepts it
// DONE  | one-cycle done pulse, err if the requested count was invalid
module digest_mem_writer
    import sha_wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 16,
    parameter int ADDR_W    = 32,
    parameter int ADDR_STEP = 4,
    parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [DATA_W*MAX_WORDS-1:0] digest_in,
    input  logic [CNT_W-1:0]            num_words,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic                        swap_bytes,
    input  logic                        mem_ready,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    if ((DATA_W % 8 != 0) || (DATA_W > SWAP_MAX_W)) begin : g_bad_width
        $error("DATA_W must be a multiple of 8 and no wider than %0d", SWAP_MAX_W);
    end

    state_t                      state, state_nx;
    logic [CNT_W-1:0]            idx;
    logic [CNT_W-1:0]            cnt_q;
    logic [ADDR_W-1:0]           base_q;
    logic                        swap_q;
    logic                        err_q;
    logic [DATA_W*MAX_WORDS-1:0] digest_q;
    logic                        count_ok;
    logic                        last_word;
    logic [DATA_W-1:0]           word_sel;

    assign count_ok  = (num_words != '0) && (num_words <= CNT_W'(MAX_WORDS));
    assign last_word = (idx == cnt_q - CNT_W'(1));

    digest_word_sel #(
        .DATA_W    (DATA_W),
        .MAX_WORDS (MAX_WORDS),
        .CNT_W     (CNT_W)
    ) u_word_sel (
        .digest (digest_q),
        .idx    (idx),
        .swap   (swap_q),
        .word   (word_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Address wraps silently: the product and sum are kept at ADDR_W bits.
    always_comb begin
        state_nx  = state;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        err       = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = count_ok ? WRITE : DONE;
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = base_q + ADDR_W'(idx) * ADDR_W'(ADDR_STEP);
                mem_wdata = word_sel;
                if (mem_ready && last_word) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                err      = err_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
            swap_q   <= 1'b0;
            err_q    <= 1'b0;
            digest_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        err_q <= !count_ok;
                        if (count_ok) begin
                            digest_q <= digest_in;
                            cnt_q    <= num_words;
                            base_q   <= base_addr;
                            swap_q   <= swap_bytes;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready && !last_word) begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_digest_mem_writer.sv
// Scoreboard bench for digest_mem_writer: the driver queues expected writes and
// completions, a negedge monitor pops and compares them as the DUT produces them.
module tb_digest_mem_writer;

    localparam int DW = 32;
    localparam int MW = 16;
    localparam int AW = 32;
    localparam int CW = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [DW*MW-1:0] digest_in = '0;
    logic [CW-1:0]  num_words = '0;
    logic [AW-1:0]  base_addr = '0;
    logic           swap_bytes = 1'b0;
    logic           mem_ready = 1'b1;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic           busy;
    logic           done;
    logic           err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit err;
        int cyc;
    } dn_t;

    wr_t exp_wr[$];
    dn_t exp_done[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_total   = 0;
    int acc_base    = 0;
    int ready_mode  = 0;
    int stall_word  = 2;
    int stall_len   = 0;
    int stalled     = 0;

    digest_mem_writer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .digest_in  (digest_in),
        .num_words  (num_words),
        .base_addr  (base_addr),
        .swap_bytes (swap_bytes),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // mode 0: always ready; 1: random; 2: stall stall_len cycles on word stall_word
    always @(posedge clk) begin
        #2;
        if (ready_mode == 0) begin
            mem_ready = 1'b1;
            stalled   = 0;
        end else if (ready_mode == 1) begin
            mem_ready = ($urandom_range(3, 0) != 0);
        end else if ((acc_total - acc_base == stall_word) && (stalled < stall_len)) begin
            mem_ready = 1'b0;
            stalled++;
        end else begin
            mem_ready = 1'b1;
        end
    end

    wr_t mon_w;
    dn_t mon_d;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                check("busy_during_write", busy, 1);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", mem_we, 0);
                end else begin
                    mon_w = exp_wr[0];
                    check("mem_addr", mem_addr, mon_w.addr);
                    check("mem_wdata", mem_wdata, mon_w.data);
                    if (mem_ready) begin
                        void'(exp_wr.pop_front());
                        acc_total++;
                    end
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    mon_d = exp_done.pop_front();
                    check("done_err", err, mon_d.err);
                    check("busy_at_done", busy, 1);
                    check("we_at_done", mem_we, 0);
                    if (mon_d.err) check("writes_left_at_err", exp_wr.size(), 0);
                    if (mon_d.cyc >= 0) check("done_cycle", cyc, mon_d.cyc);
                end
            end else begin
                check("err_without_done", err, 0);
            end
            if (!busy) begin
                check("idle_we", mem_we, 0);
                check("idle_addr", mem_addr, 0);
                check("idle_wdata", mem_wdata, 0);
            end
        end
    end

    task automatic run_txn(input logic [DW*MW-1:0] dig, input int n, input logic [31:0] base,
                           input bit swap, input bit poke);
        int c;
        bit valid;
        bit seen;
        logic [31:0] w;
        @(posedge clk); #1;
        digest_in  = dig;
        num_words  = CW'(n);
        base_addr  = base;
        swap_bytes = swap;
        start      = 1'b1;
        c          = cyc;
        acc_base   = acc_total;
        valid      = (n >= 1) && (n <= MW);
        if (valid) begin
            for (int i = 0; i < n; i++) begin
                w = dig[DW*MW-1-32*i -: 32];
                if (swap) w = {<<8{w}};
                exp_wr.push_back('{addr: base + 32'(i*4), data: w});
            end
        end
        exp_done.push_back('{err: !valid,
            cyc: (ready_mode == 1) ? -1 :
                 c + (valid ? n : 0) + 1 + ((ready_mode == 2 && n > stall_word) ? stall_len : 0)});
        @(negedge clk);
        check("busy_idle_at_start", busy, 0);
        @(posedge clk); #1;
        start      = 1'b0;
        digest_in  = {16{$urandom()}};
        base_addr  = $urandom();
        swap_bytes = ~swap;
        num_words  = CW'($urandom_range(31, 0));
        if (poke) begin
            @(posedge clk); #1;
            start     = 1'b1;
            num_words = CW'(3);
            @(posedge clk); #1;
            start = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        check("done_seen", seen, 1);
    endtask

    initial begin
        logic [DW*MW-1:0] d;
        int n;
        bit seen;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // SHA-512: data equals word index, back-to-back with the next start
        d = '0;
        for (int i = 0; i < MW; i++) d[DW*MW-1-32*i -: 32] = 32'(i);
        run_txn(d, 16, 32'h0, 1'b0, 1'b0);

        // SHA-256 with byte swap
        for (int i = 0; i < MW; i++) d[DW*MW-1-32*i -: 32] = $urandom();
        d[DW*MW-1 -: 32] = 32'h11223344;
        run_txn(d, 8, 32'h100, 1'b1, 1'b0);

        // back-pressure on word 2
        ready_mode = 2;
        stall_len  = 3;
        for (int i = 0; i < MW; i++) d[DW*MW-1-32*i -: 32] = $urandom();
        run_txn(d, 8, 32'h0, 1'b0, 1'b0);
        ready_mode = 0;

        // invalid counts
        run_txn(d, 0, 32'h40, 1'b0, 1'b0);
        run_txn(d, 17, 32'h40, 1'b0, 1'b0);

        // address wrap with an ignored start during WRITE
        run_txn(d, 4, 32'hFFFF_FFF8, 1'b0, 1'b1);

        // randomized transactions with random back-pressure
        ready_mode = 1;
        repeat (20) begin
            for (int i = 0; i < MW; i++) d[DW*MW-1-32*i -: 32] = $urandom();
            if ($urandom_range(9, 0) == 0)
                n = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(31, 17));
            else
                n = int'($urandom_range(16, 1));
            run_txn(d, n, $urandom(), 1'($urandom_range(1, 0)), 1'b0);
        end
        ready_mode = 0;

        // reset after the 5th accepted write of a 10-word transfer
        for (int i = 0; i < MW; i++) d[DW*MW-1-32*i -: 32] = $urandom();
        @(posedge clk); #1;
        digest_in  = d;
        num_words  = CW'(10);
        base_addr  = 32'h2000;
        swap_bytes = 1'b0;
        start      = 1'b1;
        acc_base   = acc_total;
        for (int i = 0; i < 10; i++)
            exp_wr.push_back('{addr: 32'h2000 + 32'(i*4), data: d[DW*MW-1-32*i -: 32]});
        exp_done.push_back('{err: 1'b0, cyc: -1});
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (acc_total - acc_base >= 5) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("five_writes_seen", seen, 1);
        check("writes_before_reset", acc_total - acc_base, 5);
        reset = 1'b1;
        exp_wr.delete();
        exp_done.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_we", mem_we, 0);
        check("post_reset_busy", busy, 0);
        check("post_reset_done", done, 0);
        repeat (4) @(negedge clk);

        // fresh start after the abort begins at word 0
        for (int i = 0; i < MW; i++) d[DW*MW-1-32*i -: 32] = $urandom();
        run_txn(d, 6, 32'h40, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
